// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if
//   Bus bundle for the multi-port register file. Clock and reset stay
//   plain ports on the module; everything else travels here.
//   master : drives write ports, read addresses and Restore
//   slave  : the register file; returns DataOut, Busy and Done
//   Signals
//     WriteEnA/WaddrA/DataInA  write port A
//     WriteEnB/WaddrB/DataInB  write port B (wins over A on same address)
//     Raddr   [NR*D]           read addresses, port k at [k*D +: D]
//     DataOut [NR*W]           read data, port k at [k*W +: W]
//     Restore                  request a restore sweep
//     Busy                     sweep in progress
//     Done                     one-cycle pulse after the sweep
interface reg_file_mp_if #(
   parameter int W  = 8,
   parameter int D  = 4,
   parameter int NR = 2
);
   logic            WriteEnA;
   logic [D-1:0]    WaddrA;
   logic [W-1:0]    DataInA;
   logic            WriteEnB;
   logic [D-1:0]    WaddrB;
   logic [W-1:0]    DataInB;
   logic [NR*D-1:0] Raddr;
   logic [NR*W-1:0] DataOut;
   logic            Restore;
   logic            Busy;
   logic            Done;

   modport master (
      output WriteEnA, WaddrA, DataInA,
      output WriteEnB, WaddrB, DataInB,
      output Raddr, Restore,
      input  DataOut, Busy, Done
   );

   modport slave (
      input  WriteEnA, WaddrA, DataInA,
      input  WriteEnB, WaddrB, DataInB,
      input  Raddr, Restore,
      output DataOut, Busy, Done
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Multi-port register file: NR combinational read ports, two write
//   ports (B has priority over A), per-entry reset values from INIT and a
//   Restore sequencer that rewrites every entry to INIT, one per cycle.
//   Ports
//     Clk    clock, all state updates on the rising edge
//     Reset  synchronous active-high reset; loads INIT, kills any sweep
//     bus    reg_file_mp_if.slave (write ports, read ports, Restore/Busy/Done)
//   Parameters
//     W, D (N = 2**D), NR, INIT (entry i at INIT[i*W +: W]), ZERO_R0
//   Build option
//     REG_FILE_BYPASS_EN  when defined, a read whose address matches an
//                         accepted write in the same cycle returns the
//                         incoming write data (B over A).

// One read lane: stored value, optionally replaced by forwarded write
// data, and masked to zero for register 0 when ZERO_R0 is set.
module reg_file_mp_rd #(
   parameter int          W       = 8,
   parameter int          D       = 4,
   parameter int unsigned ZERO_R0 = 0
) (
   input  logic [(2**D)-1:0][W-1:0] regs,
   input  logic [D-1:0]             raddr,
   input  logic                     fwd_vld,
   input  logic [W-1:0]             fwd_data,
   output logic [W-1:0]             dout
);
   always_comb begin
      dout = regs[raddr];
      if (fwd_vld) dout = fwd_data;
      if ((ZERO_R0 != 0) && (raddr == '0)) dout = '0;
   end
endmodule

module reg_file_mp #(
   parameter int                    W       = 8,
   parameter int                    D       = 4,
   parameter int                    NR      = 2,
   parameter logic [W*(2**D)-1:0]   INIT    = '0,
   parameter int unsigned           ZERO_R0 = 0
) (
   input  logic          Clk,
   input  logic          Reset,
   reg_file_mp_if.slave  bus
);
   localparam int N = 2**D;
   localparam logic [N-1:0][W-1:0] INIT_A   = INIT;
   localparam logic [D:0]          CNT_LAST = (D+1)'(N - 1);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t               state_q, state_d;
   logic [D:0]           cnt_q, cnt_d;      // one spare bit so N never aliases to 0
   logic                 done_q, done_d;
   logic [N-1:0][W-1:0]  regs_q, regs_d;
   logic                 busy;
   logic                 wr_a_ok, wr_b_ok;

   logic [NR-1:0][D-1:0] raddr;
   logic [NR-1:0][W-1:0] rdata;
   logic [NR-1:0]        fwd_vld;
   logic [NR-1:0][W-1:0] fwd_data;

   assign raddr = bus.Raddr;

   // Writes to address 0 vanish when register 0 is hardwired to zero.
   assign wr_a_ok = bus.WriteEnA && ((ZERO_R0 == 0) || (bus.WaddrA != '0));
   assign wr_b_ok = bus.WriteEnB && ((ZERO_R0 == 0) || (bus.WaddrB != '0));

   // ---------------- state register ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         regs_q  <= INIT_A;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         regs_q  <= regs_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.Restore) state_d = SWEEP;
         SWEEP:   if (cnt_q == CNT_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath / output logic ----------------
   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // A first so that B overwrites it on an address collision.
            if (wr_a_ok) regs_d[bus.WaddrA] = bus.DataInA;
            if (wr_b_ok) regs_d[bus.WaddrB] = bus.DataInB;
            if (bus.Restore) cnt_d = '0;
         end
         SWEEP: begin
            regs_d[cnt_q[D-1:0]] = INIT_A[cnt_q[D-1:0]];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) done_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy     = (state_q == SWEEP);
   assign bus.Busy = busy;
   assign bus.Done = done_q;

   // ---------------- read ports ----------------
   for (genvar k = 0; k < NR; k++) begin : g_rd
`ifdef REG_FILE_BYPASS_EN
      logic hit_a, hit_b;
      // Forward only writes that will actually land in the array.
      assign hit_a       = ~busy & wr_a_ok & (bus.WaddrA == raddr[k]);
      assign hit_b       = ~busy & wr_b_ok & (bus.WaddrB == raddr[k]);
      assign fwd_vld[k]  = hit_a | hit_b;
      assign fwd_data[k] = hit_b ? bus.DataInB : bus.DataInA;
`else
      assign fwd_vld[k]  = 1'b0;
      assign fwd_data[k] = '0;
`endif
      reg_file_mp_rd #(.W(W), .D(D), .ZERO_R0(ZERO_R0)) u_rd (
         .regs     (regs_q),
         .raddr    (raddr[k]),
         .fwd_vld  (fwd_vld[k]),
         .fwd_data (fwd_data[k]),
         .dout     (rdata[k])
      );
   end

   assign bus.DataOut = rdata;
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
   localparam int W = 8, D = 4, NR = 2, N = 16;
   // entries 1=61, 2=62, 15=128, others 0
   localparam logic [N*W-1:0] INIT_V = 128'h8000_0000_0000_0000_0000_0000_003E_3D00;

   logic Clk = 1'b0, Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic            we_a = 0, we_b = 0, restore = 0;
   logic [D-1:0]    wa_a = 0, wa_b = 0;
   logic [W-1:0]    di_a = 0, di_b = 0;
   logic [NR*D-1:0] raddr = 0;

   reg_file_mp_if #(.W(W), .D(D), .NR(NR)) bus0 ();
   reg_file_mp_if #(.W(W), .D(D), .NR(NR)) bus1 ();

   assign bus0.WriteEnA = we_a;  assign bus1.WriteEnA = we_a;
   assign bus0.WaddrA   = wa_a;  assign bus1.WaddrA   = wa_a;
   assign bus0.DataInA  = di_a;  assign bus1.DataInA  = di_a;
   assign bus0.WriteEnB = we_b;  assign bus1.WriteEnB = we_b;
   assign bus0.WaddrB   = wa_b;  assign bus1.WaddrB   = wa_b;
   assign bus0.DataInB  = di_b;  assign bus1.DataInB  = di_b;
   assign bus0.Raddr    = raddr; assign bus1.Raddr    = raddr;
   assign bus0.Restore  = restore; assign bus1.Restore = restore;

   reg_file_mp #(.W(W), .D(D), .NR(NR), .INIT(INIT_V), .ZERO_R0(0)) u0 (
      .Clk(Clk), .Reset(Reset), .bus(bus0));
   reg_file_mp #(.W(W), .D(D), .NR(NR), .INIT(INIT_V), .ZERO_R0(1)) u1 (
      .Clk(Clk), .Reset(Reset), .bus(bus1));

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_mem [N];
   bit m_busy = 0, m_done = 0, chk_en = 0;
   int m_idx = 0;

   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N; i++) m_mem[i] = INIT_V[i*W +: W];
         m_busy = 0; m_done = 0; m_idx = 0; chk_en = 1;
      end else if (m_busy) begin
         m_mem[m_idx] = INIT_V[m_idx*W +: W];
         m_idx++;
         m_done = (m_idx == N);
         if (m_done) m_busy = 0;
      end else begin
         m_done = 0;
         if (we_a) m_mem[wa_a] = di_a;
         if (we_b) m_mem[wa_b] = di_b;
         if (restore) begin m_busy = 1; m_idx = 0; end
      end
   end

   function automatic logic [W-1:0] exp_rd(input logic [D-1:0] a, input bit z);
      if (z && a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
      if (!m_busy && we_b && wa_b == a) return di_b;
      if (!m_busy && we_a && wa_a == a) return di_a;
`endif
      return m_mem[a];
   endfunction

   always @(negedge Clk) begin
      if (chk_en) begin
         for (int k = 0; k < NR; k++) begin
            chk("rd_z0", 32'(bus0.DataOut[k*W +: W]), 32'(exp_rd(raddr[k*D +: D], 0)));
            chk("rd_z1", 32'(bus1.DataOut[k*W +: W]), 32'(exp_rd(raddr[k*D +: D], 1)));
         end
         chk("busy0", 32'(bus0.Busy), 32'(m_busy));
         chk("done0", 32'(bus0.Done), 32'(m_done));
         chk("busy1", 32'(bus1.Busy), 32'(m_busy));
         chk("done1", 32'(bus1.Done), 32'(m_done));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge Clk); #2;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done_cnt;
      bit seen;
      logic [W-1:0] exp_v;

      raddr = {4'd2, 4'd1};
      tick(); tick();
      Reset = 0;
      chk("rst_r1", 32'(bus0.DataOut[7:0]), 32'd61);
      chk("rst_r2", 32'(bus0.DataOut[15:8]), 32'd62);
      chk("rst_busy", 32'(bus0.Busy), 32'd0);
      chk("rst_done", 32'(bus0.Done), 32'd0);
      raddr = {4'd0, 4'd15};
      #1 chk("rst_r15", 32'(bus0.DataOut[7:0]), 32'd128);
      chk("rst_z_r0", 32'(bus1.DataOut[15:8]), 32'd0);

      // same-address collision: B wins
      we_a = 1; wa_a = 3; di_a = 8'h11; we_b = 1; wa_b = 3; di_b = 8'h22; raddr = {4'd0, 4'd3};
      tick(); we_a = 0; we_b = 0;
      #1 chk("coll_b", 32'(bus0.DataOut[7:0]), 32'h22);

      // distinct addresses: both stored
      we_a = 1; wa_a = 4; di_a = 8'h33; we_b = 1; wa_b = 5; di_b = 8'h44; raddr = {4'd5, 4'd4};
      tick(); we_a = 0; we_b = 0;
      #1 chk("dual_a", 32'(bus0.DataOut[7:0]), 32'h33);
      chk("dual_b", 32'(bus0.DataOut[15:8]), 32'h44);

      // write/read same cycle on address 6 (old value 0)
      raddr = {4'd0, 4'd6}; we_a = 1; wa_a = 6; di_a = 8'hAB;
`ifdef REG_FILE_BYPASS_EN
      exp_v = 8'hAB;
`else
      exp_v = 8'h00;
`endif
      #1 chk("byp_same", 32'(bus0.DataOut[7:0]), 32'(exp_v));
      tick(); we_a = 0;
      #1 chk("byp_next", 32'(bus0.DataOut[7:0]), 32'hAB);

      // write to address 0: dropped on the ZERO_R0 instance
      raddr = {4'd0, 4'd0}; we_a = 1; wa_a = 0; di_a = 8'h5A;
      #1 chk("z_same", 32'(bus1.DataOut[7:0]), 32'd0);
      tick(); we_a = 0;
      #1 chk("z_next", 32'(bus1.DataOut[7:0]), 32'd0);
      chk("nz_next", 32'(bus0.DataOut[7:0]), 32'h5A);

      // fill with 0xFF
      for (int i = 0; i < N/2; i++) begin
         we_a = 1; wa_a = D'(2*i); di_a = 8'hFF;
         we_b = 1; wa_b = D'(2*i+1); di_b = 8'hFF;
         tick();
      end
      we_a = 0; we_b = 0; raddr = {4'd15, 4'd1};
      #1 chk("fill_r1", 32'(bus0.DataOut[7:0]), 32'hFF);

      // full sweep; writes and a second Restore attempted while busy
      restore = 1; tick(); restore = 0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 24; c++) begin
         if (bus0.Busy) busy_cnt++;
         if (bus0.Done) done_cnt++;
         raddr = {D'(c + 3), D'(c)};
         if (bus0.Busy) begin
            we_a = 1; wa_a = D'(c); di_a = 8'h77;
            we_b = 1; wa_b = D'(c + 5); di_b = 8'h99;
            restore = (c == 5);
         end else begin
            we_a = 0; we_b = 0; restore = 0;
         end
         tick();
      end
      we_a = 0; we_b = 0; restore = 0;
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'd16);
      chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
      for (int i = 0; i < N; i++) begin
         raddr = {D'(i ^ 1), D'(i)};
         #1 chk("sweep_reg", 32'(bus0.DataOut[7:0]), 32'(INIT_V[i*W +: W]));
      end

      // reset in the middle of a sweep
      we_a = 1; wa_a = 9; di_a = 8'hFF; we_b = 1; wa_b = 15; di_b = 8'hFF;
      tick(); we_a = 0; we_b = 0;
      restore = 1; tick(); restore = 0;
      for (int c = 0; c < 6; c++) tick();
      chk("mid_busy", 32'(bus0.Busy), 32'd1);
      Reset = 1; tick(); Reset = 0;
      chk("mid_rst_busy", 32'(bus0.Busy), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus0.Done) done_cnt++;
         raddr = {D'(c + 7), D'(c)};
         tick();
      end
      chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
      raddr = {4'd9, 4'd15};
      #1 chk("mid_rst_r15", 32'(bus0.DataOut[7:0]), 32'd128);
      chk("mid_rst_r9", 32'(bus0.DataOut[15:8]), 32'd0);

      // Restore on the Done cycle retriggers
      restore = 1; tick(); restore = 0;
      seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (bus0.Done) seen = 1; else tick();
      end
      chk("retrig_done_seen", 32'(seen), 32'd1);
      restore = 1; tick(); restore = 0;
      chk("retrig_busy", 32'(bus0.Busy), 32'd1);
      chk("retrig_done_low", 32'(bus0.Done), 32'd0);
      for (int c = 0; c < 20; c++) tick();
      chk("retrig_idle", 32'(bus0.Busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
